// File: rtl/cell_vector_tester.sv
`default_nettype none
// ============================================================================
// cell_vector_tester : exhaustive truth-table tester for one selected cell
// Optional y_i 2-flop synchronizer: define CELL_TESTER_SYNC_EN
// Revision: 1.0
// ============================================================================
module cell_vector_tester #(
    parameter int MAX_IN   = 4,
    parameter int SETTLE_W = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  start,
    input  logic                  abort,
    input  logic [2:0]            n_inputs,
    input  logic [SETTLE_W-1:0]   settle,
    input  logic [2**MAX_IN-1:0]  truth,
    output logic [MAX_IN-1:0]     drv,
    output logic                  drv_oe,
    input  logic                  y_i,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  cfg_err,
    output logic [MAX_IN:0]       err_count,
    output logic [2**MAX_IN-1:0]  mismatch
);

    localparam int c_width = 2**MAX_IN;
    localparam int c_cnt_w = SETTLE_W + 2;
    localparam logic [2:0]      c_max_n   = 3'(MAX_IN);
    localparam logic [MAX_IN:0] c_err_one = (MAX_IN+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [MAX_IN-1:0]     r_vec;
    logic [MAX_IN-1:0]     r_last_vec;
    logic [MAX_IN-1:0]     w_start_mask;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_cnt_w-1:0]    w_cnt_load;
    logic [SETTLE_W-1:0]   r_settle;
    logic [c_width-1:0]    r_truth;
    logic                  r_pass;
    logic                  r_cfg_err;
    logic [MAX_IN:0]       r_err_count;
    logic [c_width-1:0]    r_mismatch;
    logic                  w_y;
    logic                  w_cfg_bad;
    logic                  w_tick;
    logic                  w_last;
    logic                  w_miss;

`ifdef CELL_TESTER_SYNC_EN
    // Two extra cycles per window cover the synchronizer latency.
    localparam logic [c_cnt_w-1:0] c_extra = c_cnt_w'(3);
    logic r_y_meta;
    logic r_y_sync;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_y_meta <= 1'b0;
            r_y_sync <= 1'b0;
        end else begin
            r_y_meta <= y_i;
            r_y_sync <= r_y_meta;
        end
    end

    assign w_y = r_y_sync;
`else
    localparam logic [c_cnt_w-1:0] c_extra = c_cnt_w'(1);
    assign w_y = y_i;
`endif

    // Highest vector index for a run is 2^n - 1, i.e. the low n bits set.
    always_comb begin
        w_start_mask = '0;
        for (int i = 0; i < MAX_IN; i++) begin
            w_start_mask[i] = (i < int'(n_inputs));
        end
    end

    assign w_cfg_bad = (n_inputs == 3'd0) || (n_inputs > c_max_n);
    assign w_tick    = (r_cnt == '0);
    assign w_last    = (r_vec == r_last_vec);
    assign w_miss    = (w_y != r_truth[r_vec]);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        drv_oe       = 1'b0;
        done         = 1'b0;
        drv          = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = w_cfg_bad ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy   = 1'b1;
                drv_oe = 1'b1;
                drv    = r_vec;
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_tick && w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_cnt_load = c_cnt_w'(r_settle) + c_extra;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_vec       <= '0;
            r_last_vec  <= '0;
            r_cnt       <= '0;
            r_settle    <= '0;
            r_truth     <= '0;
            r_pass      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_err_count <= '0;
            r_mismatch  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_settle    <= settle;
                        r_truth     <= truth;
                        r_last_vec  <= w_start_mask;
                        r_vec       <= '0;
                        r_cnt       <= c_cnt_w'(settle) + c_extra;
                        r_pass      <= 1'b0;
                        r_cfg_err   <= w_cfg_bad;
                        r_err_count <= '0;
                        r_mismatch  <= '0;
                    end
                end
                ST_RUN: begin
                    // Abort wins over the sample on the same edge.
                    if (!abort) begin
                        if (w_tick) begin
                            if (w_miss) begin
                                r_mismatch[r_vec] <= 1'b1;
                                r_err_count       <= r_err_count + c_err_one;
                            end
                            if (w_last) begin
                                r_pass <= (r_err_count == '0) && !w_miss;
                            end else begin
                                r_vec <= r_vec + 1'b1;
                                r_cnt <= w_cnt_load;
                            end
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pass      = r_pass;
    assign cfg_err   = r_cfg_err;
    assign err_count = r_err_count;
    assign mismatch  = r_mismatch;

endmodule
`default_nettype wire

// File: doc/cell_vector_tester.md
# cell_vector_tester

On-chip stimulus/response engine for the standard-cell test structures. It drives every input combination into one selected cell's input pins, waits a programmable settle time, samples the cell's `Y` output and compares it against an expected truth table. It accumulates a mismatch map, an error count and a pass flag. It sits between the user-project control registers (start, configuration, results) and the cell-input/output mux for the cells under test.

## Interface
Parameters:
- `MAX_IN`, 4: maximum cell inputs (A..D); vector width.
- `SETTLE_W`, 4: width of the settle-count field.

Ports (`W = 2**MAX_IN`):
- `wb_clk_i`  in  1  clock.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request run; accepted only in IDLE.
- `abort`  in  1  cancel run in progress.
- `n_inputs`  in  3  input count of the selected cell; legal values 1..`MAX_IN`.
- `settle`  in  `SETTLE_W`  extra wait cycles per vector.
- `truth`  in  `W`  expected `Y` per vector; bit v corresponds to vector v.
- `drv`  out  `MAX_IN`  vector driven to cell inputs; bit0 = A, bit1 = B, bit2 = C, bit3 = D.
- `drv_oe`  out  1  enables the drivers onto the cell pins.
- `y_i`  in  1  selected cell's `Y`.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle completion pulse.
- `pass`  out  1  last run had no mismatches.
- `cfg_err`  out  1  last start request had an illegal `n_inputs`.
- `err_count`  out  `MAX_IN+1`  number of mismatching vectors.
- `mismatch`  out  `W`  bit v set if vector v mismatched.

## Operation
- States: IDLE, RUN, DONE.
- **Reset (async).** All outputs go to 0 immediately (`drv`, `drv_oe`, `busy`, `done`, `pass`, `cfg_err`, `err_count`, `mismatch`). State goes to IDLE. Reset asserted mid-run abandons the run; no `done` is produced.
- **IDLE, `start`=1.**
  - `n_inputs`, `settle` and `truth` are latched. Later changes to these inputs are ignored until the next accepted start.
  - All result outputs are cleared.
  - If `n_inputs` is 0 or greater than `MAX_IN`: `cfg_err`←1, go to DONE; `drv_oe` stays 0; `pass`=0.
  - Otherwise: vector v←0, `drv`←0, `drv_oe`←1, `busy`←1, wait counter loaded, go to RUN.
- **RUN.**
  - Each vector window lasts `settle`+2 cycles.
  - On the last edge of the window, `y_i` is sampled and compared with `truth[v]`.
  - On a mismatch: `mismatch[v]`←1 and `err_count`+1.
  - If v = 2^`n_inputs`−1, go to DONE. Otherwise v+1 and `drv` is updated on that same edge.
  - `drv` bits at or above `n_inputs` are always 0.
- **DONE (one cycle).**
  - `done`=1; `busy`=0; `drv_oe`=0; `drv`=0.
  - `pass`=1 iff `err_count`=0 and `cfg_err`=0.
  - Then go to IDLE.
- **Result persistence.** `pass`, `cfg_err`, `err_count` and `mismatch` hold until the next accepted start.
- **`start` while busy.** Ignored.
- **`abort` in RUN.** Takes priority over sampling on that edge. Next state is IDLE with `drv_oe`=0, `busy`=0 and no `done`. Partial results remain visible and `pass` stays 0.
- **`abort` in IDLE.** No effect; it does not block a simultaneous `start`.
- **`err_count` range.** Saturation is not needed; the maximum value is 2^`MAX_IN`, which fits in `MAX_IN`+1 bits.

## Timing
- Let E0 be the edge at which `start` is accepted, and S the latched `settle`.
- Vector k is driven from E0 + k·(S+2).
- `y_i` for vector k is sampled at E0 + (k+1)·(S+2).
- `done` goes high at edge E0 + 2^n·(S+2) for exactly one cycle; results are valid in that same cycle.
- With a configuration error, `done` is high in the cycle after E0.
- Back-to-back: a new `start` is accepted at the earliest on the edge after `done`.
- `busy` rises at E0 and falls when `done` rises.

## Configuration
- Macro: `CELL_TESTER_SYNC_EN`.
- **Defined:** `y_i` passes through a 2-flop synchronizer, reset to 0, before comparison. The window becomes S+4 cycles and the sample point moves 2 cycles later. `done` lands at E0 + 2^n·(S+4).
- **Undefined:** `y_i` is sampled directly, with a window of S+2 cycles.

## Test plan
1. AND2 model, `n_inputs`=2, `truth`=0x0008, S=1:
   - `drv` steps 0,1,2,3 every 3 cycles.
   - `done` at E0+12; `pass`=1, `err_count`=0, `mismatch`=0.
2. NAND2 model with AND2 truth 0x0008, S=0:
   - `done` at E0+8.
   - `err_count`=4, `mismatch`=0x000F, `pass`=0.
3. XNOR2 model, `n_inputs`=2, `truth`=0x0009, S=15:
   - Each vector is held 17 cycles; `pass`=1.
   - Change `truth` mid-run to 0x0000: result unchanged.
4. AOI22 model, `n_inputs`=4, `truth`=0x0777, S=2:
   - 16 vectors; `done` at E0+64; `pass`=1.
   - Force `y_i`=1 during vector 15: `mismatch`=0x8000, `err_count`=1.
5. `n_inputs`=0: `done` 1 cycle after E0, `cfg_err`=1, `drv_oe` never 1. Repeat with `n_inputs`=5: same result.
6. Abort and reset during a 4-input run:
   - `abort` at vector 5: `busy` falls next cycle, no `done`, `drv_oe`=0.
   - Assert `wb_rst_i` mid-run: all outputs are 0 immediately, before the next clock edge.
